// File: rtl/oserdes_pattern_gen.sv
// Square-wave word source for an 8:1 DDR OSERDES.
// Each 150 MHz cycle emits eight serial bits; OUT[7] leaves the serializer first.
// The half-period is programmable in serial-bit units through a one-entry pending slot.
// Optional macro PATTERN_GEN_DUTY_EN adds LOW_PERIOD for an independent low-phase length.
module oserdes_pattern_gen #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned DEFAULT_HALF = 4
) (
  input  logic             CLK_PARALLEL,
  input  logic             RESETN,
  input  logic             EN,
  input  logic [WIDTH-1:0] HALF_PERIOD,
  input  logic             HALF_PERIOD_VALID,
`ifdef PATTERN_GEN_DUTY_EN
  input  logic [WIDTH-1:0] LOW_PERIOD,
`endif
  output logic             HALF_PERIOD_READY,
  output logic [7:0]       OUT,
  output logic             ACTIVE,
  output logic [15:0]      EDGE_COUNT
);

  typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

  localparam logic [WIDTH-1:0] DefaultHalf = WIDTH'(DEFAULT_HALF);

  state_e           state_q;
  logic             level_q;
  logic             start_q;     // first RUN cycle: word held at zero to align latency
  logic [WIDTH-1:0] r_q;         // bits left in the current phase, including the next slot
  logic [WIDTH-1:0] h_q;
  logic [WIDTH-1:0] pend_h_q;
  logic             pend_v_q;
  logic [7:0]       out_q;
  logic [15:0]      edge_q;

  logic [WIDTH-1:0] half_in;
  logic [7:0]       gen_word;
  logic             gen_level;
  logic [WIDTH-1:0] gen_r;
  logic [WIDTH-1:0] gen_h;
  logic             gen_pend_used;
  logic             gen_stopped;
  logic [3:0]       rises;
  logic             prev_bit;

`ifdef PATTERN_GEN_DUTY_EN
  logic [WIDTH-1:0] low_q;
  logic [WIDTH-1:0] pend_l_q;
  logic [WIDTH-1:0] gen_low;
  logic [WIDTH-1:0] low_in;

  assign low_in = (LOW_PERIOD == '0) ? WIDTH'(1) : LOW_PERIOD;
`endif

  // A zero request would stall the counter, so it is promoted to one bit.
  assign half_in = (HALF_PERIOD == '0) ? WIDTH'(1) : HALF_PERIOD;

  // Unroll the eight serial slots of the next word from the registered level and counter.
  always_comb begin
    gen_word      = '0;
    gen_level     = level_q;
    gen_r         = r_q;
    gen_h         = h_q;
    gen_pend_used = 1'b0;
`ifdef PATTERN_GEN_DUTY_EN
    gen_low       = low_q;
`endif
    // Stopping with the line already low means the last pulse is complete.
    gen_stopped   = (state_q == StStop) && !level_q;
    if ((state_q != StIdle) && !start_q) begin
      for (int i = 7; i >= 0; i--) begin
        if (!gen_stopped) begin
          gen_word[i] = gen_level;
          gen_r       = gen_r - WIDTH'(1);
          if (gen_r == '0) begin
            if (gen_level) begin
              gen_level = 1'b0;
`ifdef PATTERN_GEN_DUTY_EN
              gen_r     = gen_low;
`else
              gen_r     = gen_h;
`endif
              if (state_q == StStop) begin
                gen_stopped = 1'b1;
              end
            end else begin
              gen_level = 1'b1;
              // New values only take effect at the start of a high phase.
              if (pend_v_q && !gen_pend_used) begin
                gen_h         = pend_h_q;
`ifdef PATTERN_GEN_DUTY_EN
                gen_low       = pend_l_q;
`endif
                gen_pend_used = 1'b1;
              end
              gen_r = gen_h;
            end
          end
        end
      end
    end
  end

  // Count 0->1 transitions in the word, seeded with the last bit already sent.
  always_comb begin
    rises    = '0;
    prev_bit = out_q[0];
    for (int i = 7; i >= 0; i--) begin
      if (gen_word[i] && !prev_bit) begin
        rises = rises + 4'd1;
      end
      prev_bit = gen_word[i];
    end
  end

  // Control FSM together with the pending slot, generator state and registered outputs.
  always_ff @(posedge CLK_PARALLEL or negedge RESETN) begin
    if (!RESETN) begin
      state_q  <= StIdle;
      level_q  <= 1'b0;
      start_q  <= 1'b0;
      r_q      <= DefaultHalf;
      h_q      <= DefaultHalf;
      pend_h_q <= DefaultHalf;
      pend_v_q <= 1'b0;
      out_q    <= '0;
      edge_q   <= '0;
`ifdef PATTERN_GEN_DUTY_EN
      low_q    <= DefaultHalf;
      pend_l_q <= DefaultHalf;
`endif
    end else begin
      out_q  <= gen_word;
      edge_q <= edge_q + 16'(rises);

      if (!pend_v_q && HALF_PERIOD_VALID) begin
        pend_h_q <= half_in;
        pend_v_q <= 1'b1;
`ifdef PATTERN_GEN_DUTY_EN
        pend_l_q <= low_in;
`endif
      end

      unique case (state_q)
        StIdle: begin
          level_q <= 1'b0;
          start_q <= 1'b0;
          if (pend_v_q) begin
            h_q      <= pend_h_q;
            pend_v_q <= 1'b0;
`ifdef PATTERN_GEN_DUTY_EN
            low_q    <= pend_l_q;
`endif
          end
          if (EN) begin
            state_q <= StRun;
            level_q <= 1'b1;
            start_q <= 1'b1;
            r_q     <= pend_v_q ? pend_h_q : h_q;
          end
        end
        StRun, StStop: begin
          start_q <= 1'b0;
          level_q <= gen_level;
          r_q     <= gen_r;
          h_q     <= gen_h;
`ifdef PATTERN_GEN_DUTY_EN
          low_q   <= gen_low;
`endif
          if (gen_pend_used) begin
            pend_v_q <= 1'b0;
          end
          if ((state_q == StRun) && !EN) begin
            state_q <= StStop;
          end
          if ((state_q == StStop) && gen_stopped) begin
            state_q <= StIdle;
            level_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign OUT               = out_q;
  assign ACTIVE            = (state_q != StIdle);
  assign EDGE_COUNT        = edge_q;
  assign HALF_PERIOD_READY = !pend_v_q;

endmodule

// File: tb/tb_oserdes_pattern_gen.sv
// Bench for oserdes_pattern_gen: directed words from the test plan plus a serial-stream model.
module tb_oserdes_pattern_gen;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic        hp_v = 1'b0;
  logic [15:0] hp = '0;
  logic        ready;
  logic [7:0]  out;
  logic        active;
  logic [15:0] edges;
  logic [25:0] dut_vec;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  oserdes_pattern_gen #(.WIDTH(16), .DEFAULT_HALF(4)) dut (
    .CLK_PARALLEL      (clk),
    .RESETN            (rstn),
    .EN                (en),
    .HALF_PERIOD       (hp),
    .HALF_PERIOD_VALID (hp_v),
    .HALF_PERIOD_READY (ready),
    .OUT               (out),
    .ACTIVE            (active),
    .EDGE_COUNT        (edges)
  );

  assign dut_vec = {out, active, edges, ready};

  // Reference model: a queue of future serial bits built from whole periods.
  int          m_state;   // 0 idle, 1 run, 2 stop
  bit          m_hold;
  int          m_h;
  int          m_pend;
  bit          m_pend_v;
  bit          q[$];
  logic [7:0]  m_out;
  logic [15:0] m_edges;

  function automatic void model_reset();
    m_state = 0; m_hold = 0; m_h = 4; m_pend = 0; m_pend_v = 0;
    q.delete(); m_out = '0; m_edges = '0;
  endfunction

  function automatic void append_period();
    for (int k = 0; k < m_h; k++) q.push_back(1'b1);
    for (int k = 0; k < m_h; k++) q.push_back(1'b0);
  endfunction

  function automatic logic [25:0] model_vec();
    return {m_out, (m_state != 0), m_edges, ~m_pend_v};
  endfunction

  function automatic void model_step(input bit e, input bit v, input int hv);
    bit         rdy;
    bit         stopped;
    bit         prev;
    logic [7:0] w;
    rdy = !m_pend_v;
    w   = '0;
    case (m_state)
      0: begin
        if (m_pend_v) begin m_h = m_pend; m_pend_v = 0; end
        if (e) begin q.delete(); append_period(); m_state = 1; m_hold = 1; end
      end
      1: begin
        if (m_hold) m_hold = 0;
        else begin
          // A period beginning at the first slot of the next word is fixed now.
          while (q.size() < 9) begin
            if (m_pend_v) begin m_h = m_pend; m_pend_v = 0; end
            append_period();
          end
          for (int i = 7; i >= 0; i--) w[i] = q.pop_front();
        end
        if (!e) m_state = 2;
      end
      default: begin
        stopped = 0;
        for (int i = 7; i >= 0; i--) begin
          if (!stopped) begin
            if (q.size() > 0 && q[0]) w[i] = q.pop_front();
            else stopped = 1;
          end
        end
        if (!stopped && (q.size() == 0 || !q[0])) stopped = 1;
        if (stopped) begin m_state = 0; q.delete(); end
      end
    endcase
    prev = m_out[0];
    for (int i = 7; i >= 0; i--) begin
      if (w[i] && !prev) m_edges = m_edges + 16'd1;
      prev = w[i];
    end
    m_out = w;
    if (rdy && v) begin m_pend = (hv == 0) ? 1 : hv; m_pend_v = 1; end
  endfunction

  task automatic cycle(input bit e, input bit v, input logic [15:0] h);
    en = e; hp_v = v; hp = h;
    @(posedge clk);
    model_step(e, v, int'(h));
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; en = 1'b0; hp_v = 1'b0; hp = '0;
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (out !== 8'h00) begin n_bad++; $display("FAIL reset_out: got %h want 00", out); end
    n_cmp++; if (active !== 1'b0) begin n_bad++; $display("FAIL reset_active: got %b want 0", active); end
    n_cmp++; if (edges !== 16'h0) begin n_bad++; $display("FAIL reset_edges: got %h want 0000", edges); end
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", ready); end
    do_reset();
  endtask

  task automatic test_default();
    logic [7:0] exp_w;
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      cycle(1'b1, 1'b0, 16'd0);
      exp_w = (k <= 2) ? 8'h00 : 8'hF0;
      n_cmp++; if (out !== exp_w) begin n_bad++; $display("FAIL default_word k=%0d: got %h want %h", k, out, exp_w); end
      n_cmp++; if (edges !== 16'((k <= 2) ? 0 : k - 2)) begin
        n_bad++; $display("FAIL default_edges k=%0d: got %h want %h", k, edges, (k <= 2) ? 0 : k - 2);
      end
      n_cmp++; if (active !== 1'b1) begin n_bad++; $display("FAIL default_active k=%0d: got %b want 1", k, active); end
    end
    for (int k = 0; k < 10 && active; k++) begin
      cycle(1'b0, 1'b0, 16'd0);
      n_cmp++; if (dut_vec !== model_vec()) begin
        n_bad++; $display("FAIL default_stop k=%0d: got %h want %h", k, dut_vec, model_vec());
      end
    end
    n_cmp++; if (active !== 1'b0) begin n_bad++; $display("FAIL default_stop_idle: got %b want 0", active); end
  endtask

  task automatic test_h3();
    logic [7:0] pat [3];
    int idx;
    pat[0] = 8'hE3; pat[1] = 8'h8E; pat[2] = 8'h38;
    idx = -1;
    do_reset();
    cycle(1'b0, 1'b1, 16'd3);
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 1'b0, 16'd0);
      n_cmp++; if (dut_vec !== model_vec()) begin
        n_bad++; $display("FAIL h3_model k=%0d: got %h want %h", k, dut_vec, model_vec());
      end
      if (idx < 0 && out !== 8'h00) idx = 0;
      if (idx >= 0 && idx < 6) begin
        n_cmp++; if (out !== pat[idx % 3]) begin
          n_bad++; $display("FAIL h3_word %0d: got %h want %h", idx, out, pat[idx % 3]);
        end
        idx++;
        if (idx == 6) begin
          n_cmp++; if (edges !== 16'd8) begin n_bad++; $display("FAIL h3_edges: got %h want 0008", edges); end
        end
      end
    end
    n_cmp++; if (idx != 6) begin n_bad++; $display("FAIL h3_started: got %0d words want 6", idx); end
  endtask

  task automatic test_h12_stop();
    logic [7:0] pat [3];
    int idx;
    int hi_run;
    pat[0] = 8'hFF; pat[1] = 8'hF0; pat[2] = 8'h00;
    idx = -1; hi_run = 0;
    do_reset();
    cycle(1'b0, 1'b1, 16'd12);
    for (int k = 0; k < 12; k++) begin
      cycle((k < 9) ? 1'b1 : 1'b0, 1'b0, 16'd0);
      n_cmp++; if (dut_vec !== model_vec()) begin
        n_bad++; $display("FAIL h12_model k=%0d: got %h want %h", k, dut_vec, model_vec());
      end
      for (int b = 7; b >= 0; b--) begin
        if (out[b]) hi_run++;
        else begin
          if (hi_run > 0) begin
            n_cmp++; if (hi_run != 12) begin n_bad++; $display("FAIL h12_pulse_len: got %0d want 12", hi_run); end
          end
          hi_run = 0;
        end
      end
      if (idx < 0 && out !== 8'h00) idx = 0;
      if (idx >= 0 && idx < 7) begin
        n_cmp++; if (out !== pat[idx % 3]) begin
          n_bad++; $display("FAIL h12_word %0d: got %h want %h", idx, out, pat[idx % 3]);
        end
        idx++;
      end else if (idx == 7) begin
        // EN was dropped while FF was on the output.
        n_cmp++; if ({out, active} !== {8'hF0, 1'b1}) begin
          n_bad++; $display("FAIL h12_stop_first: got %h/%b want f0/1", out, active);
        end
        idx++;
      end else if (idx == 8) begin
        n_cmp++; if ({out, active} !== {8'h00, 1'b0}) begin
          n_bad++; $display("FAIL h12_stop_second: got %h/%b want 00/0", out, active);
        end
        idx++;
      end
    end
    n_cmp++; if (idx != 9) begin n_bad++; $display("FAIL h12_sequence: got %0d want 9", idx); end
  endtask

  task automatic test_midchange();
    logic [7:0] pat [5];
    pat[0] = 8'hF0; pat[1] = 8'hF0; pat[2] = 8'hFF; pat[3] = 8'hF0; pat[4] = 8'h00;
    do_reset();
    for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 16'd0);
    cycle(1'b1, 1'b1, 16'd12);
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL mid_ready_drop: got %b want 0", ready); end
    n_cmp++; if (out !== pat[0]) begin n_bad++; $display("FAIL mid_word 0: got %h want %h", out, pat[0]); end
    for (int k = 1; k < 5; k++) begin
      cycle(1'b1, 1'b0, 16'd0);
      n_cmp++; if (out !== pat[k]) begin n_bad++; $display("FAIL mid_word %0d: got %h want %h", k, out, pat[k]); end
      n_cmp++; if (dut_vec !== model_vec()) begin
        n_bad++; $display("FAIL mid_model k=%0d: got %h want %h", k, dut_vec, model_vec());
      end
      if (k == 1) begin
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready_return: got %b want 1", ready); end
      end
    end
  endtask

  task automatic test_wrap_async_reset();
    bit          wrapped;
    bit          running;
    logic [15:0] prev_e;
    wrapped = 0; running = 0; prev_e = '0;
    do_reset();
    cycle(1'b0, 1'b1, 16'd1);
    for (int k = 0; k < 16400; k++) begin
      cycle(1'b1, 1'b0, 16'd0);
      n_cmp++; if (dut_vec !== model_vec()) begin
        n_bad++; $display("FAIL wrap_model k=%0d: got %h want %h", k, dut_vec, model_vec());
      end
      if (out !== 8'h00) begin
        n_cmp++; if (out !== 8'hAA) begin n_bad++; $display("FAIL wrap_word k=%0d: got %h want aa", k, out); end
        n_cmp++; if (edges !== prev_e + 16'd4) begin
          n_bad++; $display("FAIL wrap_step k=%0d: got %h want %h", k, edges, prev_e + 16'd4);
        end
        if (running && edges < prev_e) wrapped = 1;
        running = 1;
      end
      prev_e = edges;
    end
    n_cmp++; if (wrapped !== 1'b1) begin n_bad++; $display("FAIL wrap_seen: got %b want 1", wrapped); end
    #3;
    rstn = 1'b0;
    #1;
    n_cmp++; if ({out, active, edges, ready} !== {8'h00, 1'b0, 16'h0000, 1'b1}) begin
      n_bad++; $display("FAIL async_reset: got %h want %h", {out, active, edges, ready}, {8'h00, 1'b0, 16'h0000, 1'b1});
    end
    model_reset();
    en = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_random();
    bit          e;
    bit          v;
    logic [15:0] h;
    do_reset();
    e = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 29) == 0) e = ~e;
      v = ($urandom_range(0, 7) == 0);
      h = 16'($urandom_range(0, 20));
      cycle(e, v, h);
      n_cmp++; if (dut_vec !== model_vec()) begin
        n_bad++; $display("FAIL random_model k=%0d: got %h want %h", k, dut_vec, model_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_default();
    test_h3();
    test_h12_stop();
    test_midchange();
    test_wrap_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
